cpu_memsys: RTL and testbench

Parametrised instruction/data memory subsystem wrapping the 16-bit CPU core's IA/ID and DA/DD/RW buses. It adds a hardware program-load port, so a bench or host fills memory through a handshake instead of hierarchical preloads. It also adds a hold-off FSM that keeps the CPU in reset until loading completes, and a sticky out-of-range error flag. It sits directly beside `CPU` in the top level.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cpu_memsys_if.sv | 42 ++++
 rtl/sp_ram.sv | 39 +++
 rtl/cpu_memsys.sv | 111 +++++++++++
 tb/tb_cpu_memsys.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU memory subsystem: word/address widths,
// controller state encoding and load-port memory select codes.
package cpu_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 7;

  typedef enum logic [1:0] {
    st_load = 2'd0,
    st_hold = 2'd1,
    st_run  = 2'd2
  } state_t;

  localparam logic LD_SEL_IMEM = 1'b0;
  localparam logic LD_SEL_DMEM = 1'b1;

endpackage

// File: rtl/cpu_memsys_if.sv
// Bus bundle between the CPU/host side (master) and cpu_memsys (slave).
// The data bus dd is bidirectional and is carried as a separate port.
interface cpu_memsys_if
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  // CPU side
  logic          cpu_rst;
  logic [AW-1:0] ia;
  logic [DW-1:0] id;
  logic [AW-1:0] da;
  logic          rw;

  // Load port: a word transfers on every rising edge where ld_valid and
  // ld_ready are both high; ld_valid may be held without waiting for ld_ready,
  // and words offered while ld_ready is low are discarded.
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_sel;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_go;

  // Status / debug
  logic          err;
  state_t        state;
  logic          dd_oe;

  modport master (
    output ia, da, rw, ld_valid, ld_sel, ld_addr, ld_data, ld_go,
    input  cpu_rst, id, ld_ready, err, state, dd_oe
  );

  modport slave (
    input  ia, da, rw, ld_valid, ld_sel, ld_addr, ld_data, ld_go,
    output cpu_rst, id, ld_ready, err, state, dd_oe
  );

endinterface

// File: rtl/sp_ram.sv
// Single-port RAM with registered read and an out-of-range flag. Out-of-range
// writes are dropped and out-of-range reads return zero.
module sp_ram #(
  parameter int DW    = 16,
  parameter int AW    = 7,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          oor
);

  localparam int            IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   LIMIT = DEPTH[AW:0];

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] idx;

  assign oor = ({1'b0, addr} >= LIMIT);
  assign idx = addr[IW-1:0];

  // Array contents deliberately survive reset so a program can be re-run.
  always_ff @(posedge clk) begin
    if (we && !oor) mem[idx] <= wdata;
  end

  // Read register idles at zero whenever no valid read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              rdata <= '0;
    else if (re && !oor)  rdata <= mem[idx];
    else                  rdata <= '0;
  end

endmodule

// File: rtl/cpu_memsys.sv
// Instruction/data memory beside the CPU core, with a handshake load port, a
// LOAD/HOLD/RUN controller gating the CPU reset, and a sticky range-error flag.
module cpu_memsys
  import cpu_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int IDEPTH   = 128,
  parameter int DDEPTH   = 128,
  parameter int HOLD_CYC = 4
) (
  input  logic         ck,
  input  logic         rst,
  cpu_memsys_if.slave  bus,
  inout  wire [DW-1:0] dd
);

  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;
  logic          err_q;
  logic          load, run, ld_fire, err_set, dd_oe;

  logic          imem_we, imem_re, imem_oor;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          dmem_we, dmem_re, dmem_oor;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state    <= st_load;
      hold_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Counter preloads HOLD_CYC-1 so CPU reset drops HOLD_CYC edges after go.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      st_load: if (bus.ld_go) begin
        state_nxt = st_hold;
        hold_nxt  = CW'(HOLD_CYC - 1);
      end
      st_hold: begin
        if (hold_cnt == '0) state_nxt = st_run;
        else                hold_nxt  = hold_cnt - CW'(1);
      end
      st_run:  ;
      default: state_nxt = st_load;
    endcase
  end

  assign load = (state == st_load);
  assign run  = (state == st_run);

  // A write coinciding with reset is lost rather than committed.
  assign ld_fire   = load & bus.ld_valid & ~rst;

  assign imem_we   = ld_fire & (bus.ld_sel == LD_SEL_IMEM);
  assign imem_re   = run;
  assign imem_addr = run ? bus.ia : bus.ld_addr;

  assign dmem_we    = (ld_fire & (bus.ld_sel == LD_SEL_DMEM)) | (run & ~bus.rw & ~rst);
  assign dmem_re    = run & bus.rw;
  assign dmem_addr  = run ? bus.da : bus.ld_addr;
  assign dmem_wdata = run ? dd : bus.ld_data;

  assign err_set = (imem_oor & (imem_we | imem_re)) | (dmem_oor & (dmem_we | dmem_re));

  sp_ram #(.DW(DW), .AW(AW), .DEPTH(IDEPTH)) u_imem (
    .clk   (ck),
    .rst   (rst),
    .we    (imem_we),
    .re    (imem_re),
    .addr  (imem_addr),
    .wdata (bus.ld_data),
    .rdata (imem_rdata),
    .oor   (imem_oor)
  );

  sp_ram #(.DW(DW), .AW(AW), .DEPTH(DDEPTH)) u_dmem (
    .clk   (ck),
    .rst   (rst),
    .we    (dmem_we),
    .re    (dmem_re),
    .addr  (dmem_addr),
    .wdata (dmem_wdata),
    .rdata (dmem_rdata),
    .oor   (dmem_oor)
  );

  assign dd_oe = run & bus.rw;
  assign dd    = dd_oe ? dmem_rdata : {DW{1'bz}};

  assign bus.cpu_rst  = ~run;
  assign bus.ld_ready = load;
  assign bus.id       = imem_rdata;
  assign bus.err      = err_q;
  assign bus.state    = state;
  assign bus.dd_oe    = dd_oe;

endmodule

// File: tb/tb_cpu_memsys.sv
// Bench for cpu_memsys: two instances (hold 4 and hold 1) share one randomised
// stimulus stream and are compared against a per-instance behavioural model.
module tb_cpu_memsys;
  import cpu_pkg::*;

  localparam int DW     = 16;
  localparam int AW     = 8;
  localparam int DEPTH  = 128;
  localparam int HOLD_A = 4;
  localparam int HOLD_B = 1;
  localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH);

  // clock / reset
  logic ck  = 1'b0;
  logic rst = 1'b0;
  always #5 ck = ~ck;

  logic [AW-1:0] ia, da, ld_addr;
  logic          rw, ld_valid, ld_sel, ld_go;
  logic [DW-1:0] ld_data, wr_data;
  wire  [DW-1:0] dd_a, dd_b;

  cpu_memsys_if #(.DW(DW), .AW(AW)) if_a ();
  cpu_memsys_if #(.DW(DW), .AW(AW)) if_b ();

  assign if_a.ia = ia;  assign if_a.da = da;  assign if_a.rw = rw;
  assign if_a.ld_valid = ld_valid;  assign if_a.ld_sel = ld_sel;
  assign if_a.ld_addr = ld_addr;  assign if_a.ld_data = ld_data;  assign if_a.ld_go = ld_go;
  assign if_b.ia = ia;  assign if_b.da = da;  assign if_b.rw = rw;
  assign if_b.ld_valid = ld_valid;  assign if_b.ld_sel = ld_sel;
  assign if_b.ld_addr = ld_addr;  assign if_b.ld_data = ld_data;  assign if_b.ld_go = ld_go;

  // The CPU side drives the data bus only while writing.
  assign dd_a = rw ? {DW{1'bz}} : wr_data;
  assign dd_b = rw ? {DW{1'bz}} : wr_data;

  cpu_memsys #(.DW(DW), .AW(AW), .IDEPTH(DEPTH), .DDEPTH(DEPTH), .HOLD_CYC(HOLD_A)) u_a (
    .ck(ck), .rst(rst), .bus(if_a.slave), .dd(dd_a)
  );
  cpu_memsys #(.DW(DW), .AW(AW), .IDEPTH(DEPTH), .DDEPTH(DEPTH), .HOLD_CYC(HOLD_B)) u_b (
    .ck(ck), .rst(rst), .bus(if_b.slave), .dd(dd_b)
  );

  // reference model
  logic [DW-1:0] imem_m [2][256];
  logic [DW-1:0] dmem_m [2][256];
  bit            go_seen  [2];
  int            since_go [2];
  bit            err_m    [2];
  logic [DW-1:0] id_m     [2];
  logic [DW-1:0] rd_m     [2];
  bit            rd_valid [2];

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  function automatic int hold_of(input bit i);
    return i ? HOLD_B : HOLD_A;
  endfunction

  function automatic bit in_run(input bit i);
    return go_seen[i] && (since_go[i] >= hold_of(i));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      go_seen[1'(k)]  = 1'b0;
      since_go[1'(k)] = 0;
      err_m[1'(k)]    = 1'b0;
      id_m[1'(k)]     = '0;
      rd_m[1'(k)]     = '0;
      rd_valid[1'(k)] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit i);
    bit run_pre, load_pre;
    run_pre  = in_run(i);
    load_pre = !go_seen[i];
    rd_valid[i] = 1'b0;
    if (load_pre && ld_valid) begin
      if (ld_addr < DEPTH_L) begin
        if (ld_sel) dmem_m[i][ld_addr] = ld_data;
        else        imem_m[i][ld_addr] = ld_data;
      end else err_m[i] = 1'b1;
    end
    if (run_pre) begin
      if (ia < DEPTH_L) id_m[i] = imem_m[i][ia];
      else begin id_m[i] = '0; err_m[i] = 1'b1; end
      if (da >= DEPTH_L) err_m[i] = 1'b1;
      if (rw) begin
        rd_m[i]     = (da < DEPTH_L) ? dmem_m[i][da] : '0;
        rd_valid[i] = 1'b1;
      end else if (da < DEPTH_L) dmem_m[i][da] = wr_data;
    end else id_m[i] = '0;
    if (load_pre && ld_go) begin
      go_seen[i]  = 1'b1;
      since_go[i] = 0;
    end else if (go_seen[i] && since_go[i] < 1000) since_go[i]++;
  endtask

  // scoreboard
  task automatic chk(input string tag, input bit i, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic check_inst(input bit i);
    bit run_now;
    run_now = in_run(i);
    chk("cpu_rst",  i, 32'(i ? if_b.cpu_rst  : if_a.cpu_rst),  32'(!run_now));
    chk("ld_ready", i, 32'(i ? if_b.ld_ready : if_a.ld_ready), 32'(!go_seen[i]));
    chk("id",       i, 32'(i ? if_b.id       : if_a.id),       32'(id_m[i]));
    chk("err",      i, 32'(i ? if_b.err      : if_a.err),      32'(err_m[i]));
    chk("dd_oe",    i, 32'(i ? if_b.dd_oe    : if_a.dd_oe),    32'(run_now && rw));
    if (rd_valid[i] && rw)
      chk("dd_read", i, 32'(i ? dd_b : dd_a), 32'(rd_m[i]));
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) check_inst(1'(k));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge ck);
    if (!rst) for (int k = 0; k < 2; k++) model_edge(1'(k));
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_cpu();
    ia = '0; da = '0; rw = 1'b1; wr_data = '0;
  endtask

  task automatic random_run(input int n);
    for (int c = 0; c < n; c++) begin
      ia       = AW'($urandom_range(0, DEPTH - 1));
      da       = AW'($urandom_range(0, DEPTH - 1));
      rw       = 1'($urandom_range(0, 1));
      wr_data  = DW'($urandom);
      ld_valid = 1'($urandom_range(0, 1));
      ld_sel   = 1'($urandom_range(0, 1));
      ld_addr  = AW'($urandom_range(0, 255));
      ld_data  = DW'($urandom);
      ld_go    = 1'($urandom_range(0, 1));
      tick();
    end
    ld_valid = 1'b0; ld_go = 1'b0;
  endtask

  initial begin
    idle_cpu();
    ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; ld_go = 1'b0;

    // Reset values, then fill both memories through the load port.
    do_reset();
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      ld_valid = 1'b1; ld_sel = LD_SEL_IMEM; ld_addr = AW'(a);
      ld_data  = (a == 5) ? 16'h0513 : DW'($urandom);
      tick();
    end
    for (int a = 0; a < DEPTH; a++) begin
      ld_valid = 1'b1; ld_sel = LD_SEL_DMEM; ld_addr = AW'(a);
      ld_data  = (a == 0) ? 16'h0000 : DW'($urandom);
      tick();
    end
    ld_valid = 1'b0;

    // Go: hold-1 instance runs after one edge, hold-4 after four.
    ld_go = 1'b1;
    tick();
    ld_go = 1'b0;
    chk("hold_b_rst_high", 1'b1, 32'(if_b.cpu_rst), 32'd1);
    tick();
    chk("hold_b_rst_fall", 1'b1, 32'(if_b.cpu_rst), 32'd0);
    tick();
    tick();
    chk("hold_a_rst_high", 1'b0, 32'(if_a.cpu_rst), 32'd1);
    tick();
    chk("hold_a_rst_fall", 1'b0, 32'(if_a.cpu_rst), 32'd0);

    // Fetch and read-after-write.
    ia = 8'd5;
    tick();
    chk("fetch_ia5", 1'b0, 32'(if_a.id), 32'h0513);
    da = 8'd0; rw = 1'b0; wr_data = 16'h0004;
    tick();
    chk("dd_z_on_write", 1'b0, 32'(if_a.dd_oe), 32'd0);
    rw = 1'b1;
    tick();
    chk("raw_dd_a", 1'b0, 32'(dd_a), 32'h0004);
    chk("raw_dd_b", 1'b1, 32'(dd_b), 32'h0004);

    random_run(200);

    // Out-of-range CPU accesses.
    ia = 8'd5; da = 8'd200; rw = 1'b0; wr_data = 16'hBEEF;
    tick();
    chk("oor_write_err", 1'b0, 32'(if_a.err), 32'd1);
    rw = 1'b1;
    tick();
    chk("oor_read_zero", 1'b0, 32'(dd_a), 32'h0000);
    da = 8'd72;
    tick();
    ia = 8'd130; da = 8'd1;
    tick();
    random_run(20);

    // Asynchronous reset in the middle of RUN.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_rst_id", 1'b0, 32'(if_a.id), 32'h0000);
    tick();
    rst = 1'b0;

    // Load together with go; CPU writes in LOAD and HOLD are dropped.
    ld_valid = 1'b1; ld_sel = LD_SEL_IMEM; ld_addr = 8'd3; ld_data = 16'hC303; ld_go = 1'b1;
    ia = '0; da = 8'd7; rw = 1'b0; wr_data = 16'h1111;
    tick();
    ld_valid = 1'b0; ld_go = 1'b0; wr_data = 16'h2222;
    chk("go_same_cycle_hold", 1'b0, 32'(if_a.ld_ready), 32'd0);
    tick();
    idle_cpu();
    for (int c = 0; c < HOLD_A - 1; c++) tick();
    ia = 8'd5;
    tick();
    chk("survive_reset_ia5", 1'b0, 32'(if_a.id), 32'h0513);
    ia = 8'd3; da = 8'd7;
    tick();
    chk("load_with_go_ia3", 1'b0, 32'(if_a.id), 32'hC303);
    ld_valid = 1'b1; ld_sel = LD_SEL_IMEM; ld_addr = 8'd3; ld_data = 16'hFFFF;
    tick();
    ld_valid = 1'b0;
    tick();
    chk("run_load_ignored", 1'b0, 32'(if_a.id), 32'hC303);
    random_run(40);

    // Out-of-range loader writes.
    idle_cpu();
    do_reset();
    ld_valid = 1'b1; ld_sel = LD_SEL_IMEM; ld_addr = 8'd150; ld_data = 16'hAAAA;
    tick();
    chk("oor_load_err", 1'b0, 32'(if_a.err), 32'd1);
    ld_sel = LD_SEL_DMEM; ld_addr = 8'd255;
    tick();
    ld_valid = 1'b0; ld_go = 1'b1;
    tick();
    ld_go = 1'b0;
    for (int c = 0; c < HOLD_A; c++) tick();
    ia = 8'd22;
    tick();
    tick();
    random_run(30);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
